// File: rtl/alu_arbiter_pkg.sv
// Shared ALU function codes and legality check for the ALU arbiter slice.
package alu_arbiter_pkg;

    localparam int ALU_FN_W = 5;

    localparam logic [ALU_FN_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_FN_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_FN_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALU_FN_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALU_FN_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_FN_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALU_FN_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_FN_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_FN_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALU_FN_W-1:0] ALU_SLTU = 5'd9;
    localparam logic [ALU_FN_W-1:0] ALU_JALR = 5'd10;
    localparam logic [ALU_FN_W-1:0] ALU_X    = 5'h1F;

    // True for every function code the ALU implements; ALU_X and gaps are illegal.
    function automatic logic alu_fn_legal(input logic [ALU_FN_W-1:0] fn);
        logic legal;
        case (fn)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
            ALU_JALR: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; illegal function codes produce zero.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DW  = 32,
    parameter int FNW = ALU_FN_W
) (
    input  logic [FNW-1:0] fn,
    input  logic [DW-1:0]  src1,
    input  logic [DW-1:0]  src2,
    output logic [DW-1:0]  result
);

    logic [DW-1:0] sum;

    // Function decode; shifts use the full src2 value, JALR clears bit 0.
    always_comb begin
        sum    = src1 + src2;
        result = '0;
        case (fn)
            ALU_ADD:  result = sum;
            ALU_SUB:  result = src1 - src2;
            ALU_AND:  result = src1 & src2;
            ALU_OR:   result = src1 | src2;
            ALU_XOR:  result = src1 ^ src2;
            ALU_SLL:  result = src1 << src2;
            ALU_SRL:  result = src1 >> src2;
            ALU_SRA:  result = $signed(src1) >>> src2;
            ALU_SLT:  result = {{(DW-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_SLTU: result = {{(DW-1){1'b0}}, src1 < src2};
            ALU_JALR: result = sum & ~DW'(1);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, registered result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int FNW  = ALU_FN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*FNW-1:0] req_fn,
    input  logic [NREQ*DW-1:0] req_src1,
    input  logic [NREQ*DW-1:0] req_src2,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    localparam int IW = $clog2(NREQ);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    logic          state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;

    logic          slot_free;
    logic          grant_en;
    logic [IW:0]   pick;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] next_ptr;
    logic [FNW-1:0] alu_fn;
    logic [DW-1:0] alu_src1;
    logic [DW-1:0] alu_src2;
    logic [DW-1:0] alu_result;
    logic          fn_legal;

    // Returns {found, index} of the first valid requester starting at base.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IW-1:0]   base);
        logic [IW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(base) + k) % NREQ;
            if (!res[IW] && valid[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    // Grant selection and operand steering into the shared ALU.
    always_comb begin
        slot_free = (state == ST_IDLE) || rsp_ready[gidx];
        pick      = rr_pick(req_valid, ptr);
        grant_idx = pick[IW-1:0];
        grant_en  = !rst && !flush && slot_free && pick[IW];
        req_ready = '0;
        if (grant_en) begin
            req_ready[grant_idx] = 1'b1;
        end
        next_ptr  = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        alu_fn    = req_fn[grant_idx*FNW +: FNW];
        alu_src1  = req_src1[grant_idx*DW +: DW];
        alu_src2  = req_src2[grant_idx*DW +: DW];
        fn_legal  = alu_fn_legal(alu_fn);
    end

    alu_arbiter_alu #(
        .DW  (DW),
        .FNW (FNW)
    ) u_alu (
        .fn     (alu_fn),
        .src1   (alu_src1),
        .src2   (alu_src2),
        .result (alu_result)
    );

    // State, pointer and response register update; flush wins over handoff and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            rsp_valid <= '0;
        end else if (grant_en) begin
            state     <= ST_RESP;
            gidx      <= grant_idx;
            ptr       <= next_ptr;
            rsp_valid <= req_ready;
            rsp_data  <= fn_legal ? alu_result : '0;
            rsp_err   <= !fn_legal;
        end else if (state == ST_RESP && rsp_ready[gidx]) begin
            state     <= ST_IDLE;
            rsp_valid <= '0;
        end
    end

    assign busy = (state == ST_RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int FNW  = 5;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*FNW-1:0] req_fn;
    logic [NREQ*DW-1:0] req_src1;
    logic [NREQ*DW-1:0] req_src2;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;

    int n_tests;
    int n_fail;

    alu_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .FNW  (FNW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fn    (req_fn),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned req;
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
        req_fn[i*FNW +: FNW]  = fn;
        req_src1[i*DW +: DW]  = a;
        req_src2[i*DW +: DW]  = b;
    endtask

    initial begin
        logic [1:0] oh;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_fn    = '0;
        req_src1  = '0;
        req_src2  = '0;

        vecs[0]  = '{0, ALU_ADD,  32'd5,        32'd7,  32'd12,       1'b0};
        vecs[1]  = '{0, ALU_SUB,  32'd10,       32'd3,  32'd7,        1'b0};
        vecs[2]  = '{1, ALU_SRA,  32'h80000000, 32'd4,  32'hF8000000, 1'b0};
        vecs[3]  = '{1, ALU_SLTU, 32'd1,        32'd2,  32'd1,        1'b0};
        vecs[4]  = '{0, ALU_JALR, 32'h1001,     32'h4,  32'h1004,     1'b0};
        vecs[5]  = '{0, ALU_X,    32'd9,        32'd9,  32'd0,        1'b1};
        vecs[6]  = '{1, 5'h0B,    32'd9,        32'd9,  32'd0,        1'b1};
        vecs[7]  = '{1, ALU_SLL,  32'd1,        32'd31, 32'h80000000, 1'b0};
        vecs[8]  = '{0, ALU_SLL,  32'd1,        32'd32, 32'd0,        1'b0};
        vecs[9]  = '{1, ALU_SRL,  32'h80000000, 32'd31, 32'd1,        1'b0};
        vecs[10] = '{0, ALU_SLT,  32'hFFFFFFFF, 32'd1,  32'd1,        1'b0};
        vecs[11] = '{1, ALU_SLTU, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b0};
        vecs[12] = '{0, ALU_AND,  32'hF0F0,     32'hFF00, 32'hF000,   1'b0};
        vecs[13] = '{1, ALU_OR,   32'hF0,       32'h0F, 32'hFF,       1'b0};
        vecs[14] = '{1, ALU_XOR,  32'hFF,       32'h0F, 32'hF0,       1'b0};
        vecs[15] = '{0, ALU_SRA,  32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b0};

        // Reset values, no grant while rst is high.
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        check("rst_req_ready2", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Single transactions from the vector table.
        for (int i = 0; i < 16; i++) begin
            oh = 2'b00;
            oh[vecs[i].req] = 1'b1;
            set_req(vecs[i].req, vecs[i].fn, vecs[i].a, vecs[i].b);
            req_valid = oh;
            #1;
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(oh));
            tick();
            req_valid = 2'b00;
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(oh));
            check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
            check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            tick();
            check($sformatf("v%0d_idle_valid", i), 32'(rsp_valid), 32'h0);
            check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'h0);
            check($sformatf("v%0d_keep_data", i), rsp_data, vecs[i].exp_data);
        end

        // Back-to-back alternation from ptr=0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        set_req(1, ALU_SRA, 32'h80000000, 32'd4);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("alt%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("alt%0d_rsp_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("alt%0d_rsp_data", k), rsp_data, (k % 2 == 0) ? 32'd7 : 32'hF8000000);
        end
        req_valid = 2'b00;
        tick();
        check("alt_idle", 32'(busy), 32'h0);

        // Hold while rsp_ready1=0; rsp_ready0 is ignored; req0 granted on handoff.
        set_req(1, ALU_SLTU, 32'd1, 32'd2);
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1;
        check("hold_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'h0);
            check($sformatf("hold%0d_rsp_valid", k), 32'(rsp_valid), 32'h2);
            check($sformatf("hold%0d_rsp_data", k), rsp_data, 32'd1);
            check($sformatf("hold%0d_busy", k), 32'(busy), 32'h1);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        check("handoff_grant0", 32'(req_ready), 32'h1);
        tick();
        check("handoff_rsp_valid", 32'(rsp_valid), 32'h1);
        check("handoff_rsp_data", rsp_data, 32'd12);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
        check("handoff_idle", 32'(busy), 32'h0);

        // Flush beats handoff and request; ptr stays at 1.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        tick();
        check("pre_flush_valid", 32'(rsp_valid), 32'h1);
        flush = 1'b1;
        rsp_ready = 2'b01;
        #1;
        check("flush_no_grant", 32'(req_ready), 32'h0);
        tick();
        flush = 1'b0;
        check("flush_rsp_valid", 32'(rsp_valid), 32'h0);
        check("flush_busy", 32'(busy), 32'h0);
        set_req(1, ALU_OR, 32'h100, 32'h1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check("flush_ptr_grant1", 32'(req_ready), 32'h2);
        tick();
        check("post_flush_data", rsp_data, 32'h101);
        req_valid = 2'b00;
        tick();

        // Reset mid-RESP, then normal service.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        tick();
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rsp_data", rsp_data, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rsp_ready = 2'b11;
        #1;
        check("post_rst_grant0", 32'(req_ready), 32'h1);
        tick();
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        check("post_rst_rsp_data", rsp_data, 32'd12);
        check("post_rst_rsp_err", 32'(rsp_err), 32'h0);
        req_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
